// File: rtl/wash_phase_timer.sv
// wash_phase_timer
// Times each timed phase of the washing-machine FSM (READY delay, FILL, WASH,
// RINSE, SPIN, DRAIN) and raises the matching completion input when the
// programmed duration has elapsed.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   state[8:0]         - FSM one-hot state (IDLE=0 .. DRAIN=6, COMPLETE=7, ERROR=8)
//   pause              - freezes the counter and masks every completion output
//   cfg_we/addr/data   - duration write port (addr 0..5 = READY..DRAIN)
//   cfg_err            - one-cycle pulse, one cycle after a rejected write
//   delay_done .. draincomplete - level completion outputs, one per phase
//   phase_remaining    - current down-counter value
//   busy               - state is exactly one of the six timed codes
module wash_phase_timer #(
  parameter int CNT_W     = 16,
  parameter int DEF_READY = 4,
  parameter int DEF_FILL  = 8,
  parameter int DEF_WASH  = 16,
  parameter int DEF_RINSE = 12,
  parameter int DEF_SPIN  = 10,
  parameter int DEF_DRAIN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       state,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             cfg_err,
  output logic             delay_done,
  output logic             waterlevelreached,
  output logic             washcomplete,
  output logic             rinsecomplete,
  output logic             spincomplete,
  output logic             draincomplete,
  output logic [CNT_W-1:0] phase_remaining,
  output logic             busy
);

  localparam logic [8:0] ST_IDLE     = 9'b000000001;
  localparam logic [8:0] ST_COMPLETE = 9'b010000000;
  localparam logic [8:0] ST_ERROR    = 9'b100000000;

  localparam logic [CNT_W-1:0] DEF_DUR [0:5] = '{
    CNT_W'(DEF_READY), CNT_W'(DEF_FILL), CNT_W'(DEF_WASH),
    CNT_W'(DEF_RINSE), CNT_W'(DEF_SPIN), CNT_W'(DEF_DRAIN)
  };

  logic [CNT_W-1:0] dur_q [0:5];
  logic [CNT_W-1:0] dur_d [0:5];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       prev_state_q, prev_state_d;
  logic             cfg_err_q, cfg_err_d;

  logic             timed;
  logic [CNT_W-1:0] load_raw;
  logic             cfg_state_ok;
  logic             cfg_addr_ok;
  logic             cfg_accept;
  logic             phase_done;

  // Decode the timed phase and pick its stored duration. Anything that is
  // not exactly one of the six timed codes (including zero and multi-hot)
  // counts as non-timed.
  always_comb begin
    timed    = 1'b1;
    load_raw = '0;
    case (state)
      9'b000000010: load_raw = dur_q[0];
      9'b000000100: load_raw = dur_q[1];
      9'b000001000: load_raw = dur_q[2];
      9'b000010000: load_raw = dur_q[3];
      9'b000100000: load_raw = dur_q[4];
      9'b001000000: load_raw = dur_q[5];
      default:      timed    = 1'b0;
    endcase
  end

  // Configuration: writes land only while the FSM is parked.
  always_comb begin
    cfg_state_ok = (state == ST_IDLE) || (state == ST_COMPLETE) || (state == ST_ERROR);
    cfg_addr_ok  = (cfg_addr <= 3'd5);
    cfg_accept   = cfg_we && cfg_state_ok && cfg_addr_ok;
    cfg_err_d    = cfg_we && !(cfg_state_ok && cfg_addr_ok);
    for (int i = 0; i < 6; i++) begin
      dur_d[i] = (cfg_accept && (cfg_addr == 3'(i))) ? cfg_data : dur_q[i];
    end
  end

  // Counter: clear outside timed phases, reload on any entry (a stored 0
  // loads as 1), otherwise count down unless paused, saturating at 0.
  always_comb begin
    prev_state_d = state;
    cnt_d        = cnt_q;
    if (!timed) begin
      cnt_d = '0;
    end else if (state != prev_state_q) begin
      cnt_d = (load_raw == '0) ? CNT_W'(1) : load_raw;
    end else if (!pause && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      prev_state_q <= ST_IDLE;
      cfg_err_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        dur_q[i] <= DEF_DUR[i];
      end
    end else begin
      cnt_q        <= cnt_d;
      prev_state_q <= prev_state_d;
      cfg_err_q    <= cfg_err_d;
      for (int i = 0; i < 6; i++) begin
        dur_q[i] <= dur_d[i];
      end
    end
  end

  // Requiring prev_state == state keeps the entry cycle quiet even when the
  // counter still holds a stale 0 from the previous phase.
  always_comb begin
    phase_done        = timed && (state == prev_state_q) && (cnt_q == '0) && !pause;
    delay_done        = phase_done && state[1];
    waterlevelreached = phase_done && state[2];
    washcomplete      = phase_done && state[3];
    rinsecomplete     = phase_done && state[4];
    spincomplete      = phase_done && state[5];
    draincomplete     = phase_done && state[6];
    phase_remaining   = cnt_q;
    busy              = timed;
    cfg_err           = cfg_err_q;
  end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer. The bench plays the washing-machine
// FSM: it advances state one cycle after the matching completion output.
module tb_wash_phase_timer;

  localparam logic [8:0] IDLE     = 9'b000000001;
  localparam logic [8:0] READY    = 9'b000000010;
  localparam logic [8:0] FILL     = 9'b000000100;
  localparam logic [8:0] WASH     = 9'b000001000;
  localparam logic [8:0] RINSE    = 9'b000010000;
  localparam logic [8:0] SPIN     = 9'b000100000;
  localparam logic [8:0] DRAIN    = 9'b001000000;
  localparam logic [8:0] COMPLETE = 9'b010000000;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  state;
  logic        pause;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_err;
  logic        delay_done, waterlevelreached, washcomplete;
  logic        rinsecomplete, spincomplete, draincomplete;
  logic [15:0] phase_remaining;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wash_phase_timer dut (
    .clk               (clk),
    .reset             (reset),
    .state             (state),
    .pause             (pause),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_err           (cfg_err),
    .delay_done        (delay_done),
    .waterlevelreached (waterlevelreached),
    .washcomplete      (washcomplete),
    .rinsecomplete     (rinsecomplete),
    .spincomplete      (spincomplete),
    .draincomplete     (draincomplete),
    .phase_remaining   (phase_remaining),
    .busy              (busy)
  );

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [5:0] done_vec();
    return {draincomplete, spincomplete, rinsecomplete,
            washcomplete, waterlevelreached, delay_done};
  endfunction

  // driver tasks: every cycle starts 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter phase p (0=READY..5=DRAIN) with stored duration d, wait for its
  // completion output and hand control back one cycle later.
  task automatic run_phase(input int p, input int d, input string tag);
    int          lat;
    int          d_eff;
    logic [5:0]  dv;
    d_eff = (d == 0) ? 1 : d;
    state = 9'(1) << (p + 1);
    #1;
    dv = done_vec();
    check_eq({tag, "_entry_quiet"}, 32'(dv), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (dv[p] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      dv = done_vec();
      if (lat == 1) check_eq({tag, "_loaded"}, 32'(phase_remaining), 32'(d_eff));
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(d_eff + 1));
    check_eq({tag, "_onehot"}, 32'(dv), 32'(6'b1 << p));
    tick();
  endtask

  task automatic run_full(input int d_wash, input string tag);
    state = IDLE;
    tick();
    run_phase(0, 4,      {tag, "_ready"});
    run_phase(1, 8,      {tag, "_fill"});
    run_phase(2, d_wash, {tag, "_wash"});
    run_phase(3, 12,     {tag, "_rinse"});
    run_phase(4, 10,     {tag, "_spin"});
    run_phase(5, 6,      {tag, "_drain"});
    state = COMPLETE;
    #1;
    check_eq({tag, "_complete_idle"}, 32'(busy), 32'd0);
    tick();
    state = IDLE;
    tick();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d,
                           input logic exp_err, input string tag);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    check_eq({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    tick();
    check_eq({tag, "_err_clr"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int         lat;
    logic [5:0] dv;
    reset    = 1'b1;
    state    = IDLE;
    pause    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    tick();
    tick();
    check_eq("rst_remaining", 32'(phase_remaining), 32'd0);
    check_eq("rst_done", 32'(done_vec()), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    #2 reset = 1'b0;
    repeat (6) tick();

    // defaults through a whole wash
    run_full(16, "dflt");

    // reprogram WASH
    cfg_write(3'd2, 16'd3, 1'b0, "wr_wash3");
    run_full(3, "wash3");
    cfg_write(3'd2, 16'd0, 1'b0, "wr_wash0");
    run_full(0, "wash0");

    // rejected writes: valid address during WASH, then invalid address in IDLE
    state = WASH;
    #1;
    cfg_write(3'd1, 16'd50, 1'b1, "wr_in_wash");
    state = IDLE;
    tick();
    run_phase(1, 8, "fill_after_rej");
    state = IDLE;
    tick();
    cfg_write(3'd7, 16'd9, 1'b1, "wr_addr7");

    // pause in RINSE at cnt=6 for 5 cycles
    state = RINSE;
    #1;
    repeat (7) tick();
    check_eq("rinse_at6", 32'(phase_remaining), 32'd6);
    pause = 1'b1;
    repeat (5) tick();
    pause = 1'b0;
    #1;
    check_eq("rinse_held", 32'(phase_remaining), 32'd6);
    lat = 12;
    dv  = done_vec();
    while (dv[3] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      dv = done_vec();
    end
    check_eq("rinse_paused_latency", 32'(lat), 32'd18);
    pause = 1'b1;
    #1;
    check_eq("rinse_mask", 32'(rinsecomplete), 32'd0);
    tick();
    check_eq("rinse_mask2", 32'(rinsecomplete), 32'd0);
    check_eq("rinse_cnt0", 32'(phase_remaining), 32'd0);
    pause = 1'b0;
    #1;
    check_eq("rinse_reassert", 32'(rinsecomplete), 32'd1);
    tick();

    // cancel SPIN at cnt=3, then re-enter READY
    state = SPIN;
    #1;
    repeat (8) tick();
    check_eq("spin_at3", 32'(phase_remaining), 32'd3);
    state = IDLE;
    tick();
    check_eq("cancel_cleared", 32'(phase_remaining), 32'd0);
    run_phase(0, 4, "reentry_ready");
    state = IDLE;
    tick();

    // non-timed encodings
    state = 9'b000001100;
    tick();
    check_eq("multihot_busy", 32'(busy), 32'd0);
    check_eq("multihot_cnt", 32'(phase_remaining), 32'd0);
    check_eq("multihot_done", 32'(done_vec()), 32'd0);
    state = 9'b0;
    tick();
    check_eq("zero_busy", 32'(busy), 32'd0);

    // async reset in DRAIN at cnt=2; WASH is still programmed to 0 here
    state = DRAIN;
    #1;
    repeat (5) tick();
    check_eq("drain_at2", 32'(phase_remaining), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_eq("amid_rst_remaining", 32'(phase_remaining), 32'd0);
    check_eq("amid_rst_done", 32'(done_vec()), 32'd0);
    state = IDLE;
    tick();
    #2 reset = 1'b0;
    tick();
    run_full(16, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Programmable phase sequencer that drives the washing-machine FSM's phase-completion inputs. It watches the FSM's one-hot `state` bus and times each timed phase (READY delay, FILL, WASH, RINSE, SPIN, DRAIN) with a per-phase duration register. When the duration expires it asserts the matching completion input. It sits beside the FSM and replaces the external sensor/timer stubs in simulation and in timer-only builds.

## Interface
- `CNT_W`, 16: width of duration registers and phase counter.
- `DEF_READY`, 4: reset duration for the READY delay (cycles).
- `DEF_FILL`, 8: reset duration for FILL.
- `DEF_WASH`, 16: reset duration for WASH.
- `DEF_RINSE`, 12: reset duration for RINSE.
- `DEF_SPIN`, 10: reset duration for SPIN.
- `DEF_DRAIN`, 6: reset duration for DRAIN.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `state` in 9: FSM one-hot state. Bit encoding:
  - IDLE=bit0, READY=bit1, FILL=bit2, WASH=bit3, RINSE=bit4
  - SPIN=bit5, DRAIN=bit6, COMPLETE=bit7, ERROR=bit8.
- `pause` in 1: freezes the counter and masks all completion outputs.
- `cfg_we` in 1: duration write strobe.
- `cfg_addr` in 3: duration select. 0=READY, 1=FILL, 2=WASH, 3=RINSE, 4=SPIN, 5=DRAIN. Addresses 6 and 7 are invalid.
- `cfg_data` in CNT_W: duration value in cycles.
- `cfg_err` out 1: registered one-cycle pulse on a rejected write.
- `delay_done`, `waterlevelreached`, `washcomplete`, `rinsecomplete`, `spincomplete`, `draincomplete` out 1 each: level completion outputs, one per timed phase.
- `phase_remaining` out CNT_W: current counter value.
- `busy` out 1: high when `state` is exactly one of the six timed one-hot codes.

## Operation
- **Reset values:**
  - duration registers = DEF_* values; `cnt` = 0.
  - `prev_state` = 9'b000000001.
  - `cfg_err` = 0; all completion outputs = 0; `phase_remaining` = 0.
- **Registers:**
  - `prev_state` samples `state` every cycle.
  - `cnt` is the CNT_W-bit down-counter.
- **Timed phase:** `state` equals exactly one of the READY..DRAIN one-hot codes. Any other value is non-timed: IDLE, COMPLETE, ERROR, zero, or multi-hot.
- **Counter update, in priority order:**
  1. Non-timed `state`: `cnt` <= 0.
  2. Entry (timed and `state` != `prev_state`): `cnt` <= max(dur[phase], 1). `pause` does not block the load.
  3. In phase (timed and `state` == `prev_state`), `pause`=0 and `cnt`!=0: `cnt` <= `cnt` - 1.
  4. Otherwise `cnt` holds. It never wraps below 0.
- **Completion output** for phase X (combinational from registers and inputs): asserted when all of the following hold.
  - `state` == X
  - `prev_state` == X
  - `cnt` == 0
  - `pause` == 0

  It stays high while those conditions hold, because the FSM may be held in X by fault or cancel priority. At most one completion output is high at a time.
- **Re-entry:** a phase left and re-entered (e.g. cancel → IDLE → READY) always reloads the full duration.
- **Configuration writes:**
  - Accepted only when `state` is IDLE, COMPLETE or ERROR, and `cfg_addr` is 0..5.
  - An accepted write takes effect at the clock edge. A phase entered on the next cycle uses the new value.
  - A write with a valid address in any other state is ignored, and `cfg_err` pulses one cycle later.
  - A write to address 6 or 7 in any state is ignored, and `cfg_err` pulses one cycle later.
  - A `cfg_data` value of 0 is stored as 0 and treated as 1 on load.
- **Reset mid-phase:** `cnt` clears immediately and durations revert to DEF_*. Completion outputs drop at once because `prev_state` becomes IDLE.

## Timing
- Phase X first visible on `state` in cycle T, with stored duration D≥1 and no pause:
  - `cnt` = D in T+1, decrementing to 0 in T+D+1.
  - The completion output is high in T+D+1.
  - The FSM shows the next state in T+D+2.
  - Total phase occupancy is D+2 cycles; D=0 behaves as D=1.
- A pause of P cycles while `cnt`>0 extends the phase by exactly P cycles.
- A pause while `cnt`==0 only masks the output; the output reasserts in the first cycle with `pause`=0.
- Completion outputs are never asserted in the entry cycle T, even if `cnt` holds a stale 0.
- `cfg_err` latency is 1 cycle; `cfg_err` is not asserted for accepted writes.
- No combinational path from `cfg_*` to the completion outputs.

## Test plan
- **Defaults, full cycle.** Reset, then drive the FSM IDLE→READY at T=10 with the FSM model closing the loop.
  - `delay_done` high in cycle 15.
  - `waterlevelreached` high 9 cycles after FILL entry; `washcomplete` 17 cycles after WASH entry.
  - Phases sequence through to COMPLETE, with exactly one completion output per phase.
- **Reprogramming.** In IDLE, write addr 2 = 3, then start a full cycle.
  - `washcomplete` high 4 cycles after WASH entry.
  - Write addr 2 = 0, run again: `washcomplete` high 2 cycles after WASH entry.
- **Rejected writes.**
  - Write addr 1 = 50 while in WASH: `cfg_err` pulses one cycle later, and a later FILL still takes 9 cycles.
  - Write addr 7 while in IDLE: `cfg_err` pulses one cycle later.
- **Pause.**
  - In RINSE (D=12), assert `pause` for 5 cycles at `cnt`=6: `rinsecomplete` is delayed by 5 cycles.
  - Assert `pause` with `cnt`=0: `rinsecomplete` is 0 while `pause` is high and reasserts the first cycle `pause` is low.
- **Cancel and re-entry.** Force `state` SPIN→IDLE at `cnt`=3.
  - `cnt`=0 next cycle.
  - Re-enter READY: the full 4-cycle delay is reloaded, with `delay_done` at entry+5.
- **Async reset mid-phase.** Assert `reset` between edges during DRAIN with `cnt`=2.
  - All outputs drop to 0 immediately.
  - `phase_remaining`=0.
  - Durations read back as defaults on the next run.
